// File: rtl/mem_bus_arbiter.sv
// Arbitrates one SRAM-style bus between instruction fetch and MEM-stage data access.
// One transaction is outstanding at a time; finished results are held until the pipeline advances.
module mem_bus_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int DATA_FIRST = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pipe_stall,
    input  logic                i_en,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_wait,
    input  logic                d_en,
    input  logic [DATA_W/8-1:0] d_wen,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_wait,
    output logic                bus_req,
    output logic                bus_wr,
    output logic [DATA_W/8-1:0] bus_wstrb,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic                bus_addr_ok,
    input  logic                bus_data_ok,
    input  logic [DATA_W-1:0]   bus_rdata
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {IDLE, I_ADDR, I_DATA, D_ADDR, D_DATA} state_t;

    state_t              state_reg;
    logic                bus_req_reg;
    logic                bus_wr_reg;
    logic [STRB_W-1:0]   bus_wstrb_reg;
    logic [ADDR_W-1:0]   bus_addr_reg;
    logic [DATA_W-1:0]   bus_wdata_reg;

    // Index 0 is the fetch side, index 1 the data side.
    logic [1:0]          side_en;
    logic [1:0]          side_fin;
    logic [1:0]          side_done;
    logic [1:0]          side_wait;
    logic [DATA_W-1:0]   side_rdata [2];
    logic                pend_i;
    logic                pend_d;

    assign side_en     = {d_en, i_en};
    assign side_fin[0] = (state_reg == I_DATA) && bus_data_ok;
    assign side_fin[1] = (state_reg == D_DATA) && bus_data_ok;
    assign pend_i      = i_en & ~side_done[0];
    assign pend_d      = d_en & ~side_done[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            bus_req_reg   <= 1'b0;
            bus_wr_reg    <= 1'b0;
            bus_wstrb_reg <= '0;
            bus_addr_reg  <= '0;
            bus_wdata_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pend_d && ((DATA_FIRST != 0) || !pend_i)) begin
                        state_reg     <= D_ADDR;
                        bus_req_reg   <= 1'b1;
                        bus_wr_reg    <= |d_wen;
                        bus_wstrb_reg <= d_wen;
                        bus_addr_reg  <= d_addr;
                        bus_wdata_reg <= d_wdata;
                    end else if (pend_i) begin
                        state_reg     <= I_ADDR;
                        bus_req_reg   <= 1'b1;
                        bus_wr_reg    <= 1'b0;
                        bus_wstrb_reg <= '0;
                        bus_addr_reg  <= i_addr;
                        bus_wdata_reg <= '0;
                    end
                end
                I_ADDR, D_ADDR: begin
                    if (bus_addr_ok) begin
                        state_reg   <= (state_reg == I_ADDR) ? I_DATA : D_DATA;
                        bus_req_reg <= 1'b0;
                    end
                end
                I_DATA, D_DATA: begin
                    // A flushed requester still waits out its data_ok; the result is simply dropped.
                    if (bus_data_ok) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_side
            logic              done_reg;
            logic [DATA_W-1:0] buf_reg;

            // A completion seen at an advancing edge is consumed directly, so done is only set while stalled.
            always_ff @(posedge clk) begin
                if (rst) begin
                    done_reg <= 1'b0;
                    buf_reg  <= '0;
                end else begin
                    if (side_fin[gi] && side_en[gi]) begin
                        buf_reg <= bus_rdata;
                    end
                    if (!pipe_stall) begin
                        done_reg <= 1'b0;
                    end else if (side_fin[gi] && side_en[gi]) begin
                        done_reg <= 1'b1;
                    end
                end
            end

            assign side_done[gi]  = done_reg;
            assign side_wait[gi]  = rst ? side_en[gi]
                                        : (side_en[gi] & ~done_reg & ~side_fin[gi]);
            assign side_rdata[gi] = rst ? '0 : (done_reg ? buf_reg : bus_rdata);
        end
    endgenerate

    assign i_wait    = side_wait[0];
    assign d_wait    = side_wait[1];
    assign i_rdata   = side_rdata[0];
    assign d_rdata   = side_rdata[1];
    assign bus_req   = bus_req_reg;
    assign bus_wr    = bus_wr_reg;
    assign bus_wstrb = bus_wstrb_reg;
    assign bus_addr  = bus_addr_reg;
    assign bus_wdata = bus_wdata_reg;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a bus responder model, a scoreboard of expected
// bus requests and read results, and a monitor that checks whenever the DUT presents them.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_stall;
    logic        i_en;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_wait;
    logic        d_en;
    logic [3:0]  d_wen;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_wait;
    logic        bus_req;
    logic        bus_wr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } bus_t;

    bus_t        exp_bus [$];
    logic [31:0] exp_i   [$];
    logic [31:0] exp_d   [$];
    logic [31:0] rsp_q   [$];

    int pass_cnt    = 0;
    int total_cnt   = 0;
    int breq_cycles = 0;
    int addr_dly    = 0;
    int data_dly    = 1;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_FIRST(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_stall (pipe_stall),
        .i_en       (i_en),
        .i_addr     (i_addr),
        .i_rdata    (i_rdata),
        .i_wait     (i_wait),
        .d_en       (d_en),
        .d_wen      (d_wen),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_wait     (d_wait),
        .bus_req    (bus_req),
        .bus_wr     (bus_wr),
        .bus_wstrb  (bus_wstrb),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_addr_ok(bus_addr_ok),
        .bus_data_ok(bus_data_ok),
        .bus_rdata  (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // which: 0 fetch complete, 1 data complete, 2 addr_ok, 3 data_ok, 4 bus_req
    task automatic wait_for(input int which, input string nm);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < 60 && !hit; k++) begin
            @(negedge clk);
            case (which)
                0:       hit = i_en && !i_wait;
                1:       hit = d_en && !d_wait;
                2:       hit = bus_addr_ok;
                3:       hit = bus_data_ok;
                default: hit = bus_req;
            endcase
        end
        if (!hit) begin
            total_cnt++;
            $display("FAIL %s: no event seen, required one within 60 cycles", nm);
        end
    endtask

    task automatic push_bus(input logic [31:0] a, input logic w, input logic [3:0] s,
                            input logic [31:0] wd);
        bus_t e;
        e.addr  = a;
        e.wr    = w;
        e.strb  = s;
        e.wdata = wd;
        exp_bus.push_back(e);
    endtask

    // Pipeline takes the result: one stalled edge, then one advancing edge with the request dropped.
    task automatic consume(input bit is_d);
        tick();
        if (is_d) d_en = 1'b0;
        else      i_en = 1'b0;
        pipe_stall = 1'b0;
        tick();
        pipe_stall = 1'b1;
    endtask

    // Bus responder: addr_ok after addr_dly request cycles, data_ok data_dly cycles later.
    initial begin
        int phase;
        int cnt;
        phase = 0;
        cnt   = 0;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        bus_rdata   = 32'h5A5A5A5A;
        forever begin
            tick();
            bus_addr_ok = 1'b0;
            bus_data_ok = 1'b0;
            bus_rdata   = 32'h5A5A5A5A;
            if (rst) begin
                phase = 0;
                cnt   = 0;
            end else if (phase == 0) begin
                if (bus_req) begin
                    if (cnt == addr_dly) begin
                        bus_addr_ok = 1'b1;
                        phase = 1;
                        cnt   = 0;
                    end else begin
                        cnt++;
                    end
                end else begin
                    cnt = 0;
                end
            end else begin
                cnt++;
                if (cnt >= data_dly) begin
                    bus_data_ok = 1'b1;
                    bus_rdata   = (rsp_q.size() > 0) ? rsp_q.pop_front() : 32'hDEADBEEF;
                    phase = 0;
                    cnt   = 0;
                end
            end
        end
    end

    // Monitor: compares bus address phases and read completions against the scoreboard.
    initial begin
        bit   i_prev;
        bit   d_prev;
        bus_t e;
        i_prev = 1'b0;
        d_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_req) breq_cycles++;
            if (!rst && bus_req && bus_addr_ok) begin
                if (exp_bus.size() == 0) begin
                    total_cnt++;
                    $display("FAIL bus_unexpected: got request addr %h, required none", bus_addr);
                end else begin
                    e = exp_bus.pop_front();
                    check("bus_addr",  bus_addr,           e.addr);
                    check("bus_wr",    32'(bus_wr),        32'(e.wr));
                    check("bus_wstrb", 32'(bus_wstrb),     32'(e.strb));
                    check("bus_wdata", bus_wdata,          e.wdata);
                end
            end
            if (!rst && i_en && !i_wait && i_prev) begin
                if (exp_i.size() == 0) begin
                    total_cnt++;
                    $display("FAIL i_unexpected: got completion %h, required none", i_rdata);
                end else begin
                    check("i_rdata", i_rdata, exp_i.pop_front());
                end
            end
            if (!rst && d_en && !d_wait && d_prev && d_wen == 4'b0000) begin
                if (exp_d.size() == 0) begin
                    total_cnt++;
                    $display("FAIL d_unexpected: got completion %h, required none", d_rdata);
                end else begin
                    check("d_rdata", d_rdata, exp_d.pop_front());
                end
            end
            i_prev = !rst && i_en && i_wait;
            d_prev = !rst && d_en && d_wait;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; pipe_stall = 1'b1;
        i_en = 1'b1; i_addr = 32'h0;
        d_en = 1'b1; d_wen = 4'b0; d_addr = 32'h0; d_wdata = 32'h0;
        repeat (2) tick();
        @(negedge clk);
        check("rst_i_wait",  32'(i_wait),    32'd1);
        check("rst_d_wait",  32'(d_wait),    32'd1);
        check("rst_i_rdata", i_rdata,        32'h0);
        check("rst_d_rdata", d_rdata,        32'h0);
        check("rst_bus_req", 32'(bus_req),   32'd0);
        check("rst_bus_wr",  32'(bus_wr),    32'd0);
        check("rst_strb",    32'(bus_wstrb), 32'd0);
        check("rst_addr",    bus_addr,       32'h0);
        check("rst_wdata",   bus_wdata,      32'h0);
        tick();
        rst = 1'b0; i_en = 1'b0; d_en = 1'b0;
        tick();

        // T1 lone fetch
        addr_dly = 0; data_dly = 2; breq_cycles = 0;
        push_bus(32'hBFC00000, 1'b0, 4'b0, 32'h0);
        rsp_q.push_back(32'h24080001);
        exp_i.push_back(32'h24080001);
        i_en = 1'b1; i_addr = 32'hBFC00000;
        wait_for(0, "t1_fetch_done");
        check("t1_done_on_data_ok", 32'(bus_data_ok), 32'd1);
        consume(1'b0);
        check("t1_req_cycles", 32'(breq_cycles), 32'd1);

        // T2 collision, T3 stall hold
        addr_dly = 0; data_dly = 1;
        push_bus(32'h80001000, 1'b0, 4'b0, 32'h0);
        push_bus(32'hBFC00004, 1'b0, 4'b0, 32'h0);
        rsp_q.push_back(32'h11112222);
        rsp_q.push_back(32'h33334444);
        exp_d.push_back(32'h11112222);
        exp_i.push_back(32'h33334444);
        i_en = 1'b1; i_addr = 32'hBFC00004;
        d_en = 1'b1; d_wen = 4'b0; d_addr = 32'h80001000;
        wait_for(1, "t2_d_done");
        check("t2_i_wait_during_d", 32'(i_wait), 32'd1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("t3_d_wait_hold",  32'(d_wait), 32'd0);
            check("t3_d_rdata_hold", d_rdata,     32'h11112222);
            check("t3_i_still_wait", 32'(i_wait), 32'd1);
        end
        wait_for(0, "t2_i_done");
        check("t3_d_rdata_at_i", d_rdata, 32'h11112222);
        tick();
        pipe_stall = 1'b0; i_en = 1'b0; d_addr = 32'h80001004;
        push_bus(32'h80001004, 1'b0, 4'b0, 32'h0);
        rsp_q.push_back(32'h55556666);
        exp_d.push_back(32'h55556666);
        tick();
        pipe_stall = 1'b1;
        @(negedge clk);
        check("t3_d_done_cleared", 32'(d_wait), 32'd1);
        wait_for(1, "t3_next_load_done");
        consume(1'b1);

        // T4 partial store with slow addr_ok
        addr_dly = 2; data_dly = 1; breq_cycles = 0;
        push_bus(32'h80000010, 1'b1, 4'b0100, 32'hABABABAB);
        rsp_q.push_back(32'h0);
        d_en = 1'b1; d_wen = 4'b0100; d_addr = 32'h80000010; d_wdata = 32'hABABABAB;
        wait_for(1, "t4_store_done");
        consume(1'b1);
        d_wen = 4'b0;
        check("t4_req_cycles", 32'(breq_cycles), 32'd3);

        // T5 flush during I_DATA
        addr_dly = 0; data_dly = 3;
        push_bus(32'hBFC00100, 1'b0, 4'b0, 32'h0);
        rsp_q.push_back(32'h77778888);
        i_en = 1'b1; i_addr = 32'hBFC00100;
        wait_for(2, "t5_addr_ok");
        tick();
        i_en = 1'b0;
        wait_for(3, "t5_data_ok");
        tick();
        data_dly = 1;
        push_bus(32'hBFC00200, 1'b0, 4'b0, 32'h0);
        rsp_q.push_back(32'h9999AAAA);
        exp_i.push_back(32'h9999AAAA);
        i_en = 1'b1; i_addr = 32'hBFC00200;
        @(negedge clk);
        check("t5_no_done_after_flush", 32'(i_wait), 32'd1);
        wait_for(0, "t5_refetch_done");
        consume(1'b0);

        // T6 reset during D_ADDR
        addr_dly = 5;
        d_en = 1'b1; d_wen = 4'b0; d_addr = 32'h80002000;
        wait_for(4, "t6_req");
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("t6_d_wait_in_rst",  32'(d_wait), 32'd1);
        check("t6_d_rdata_in_rst", d_rdata,     32'h0);
        tick();
        @(negedge clk);
        check("t6_bus_req",  32'(bus_req),               32'd0);
        check("t6_state",    32'(dut.state_reg),         32'd0);
        check("t6_d_done",   32'(dut.g_side[1].done_reg), 32'd0);
        check("t6_i_done",   32'(dut.g_side[0].done_reg), 32'd0);
        tick();
        rst = 1'b0; d_en = 1'b0;
        tick();
        tick();
        check("end_bus_queue", 32'(exp_bus.size()), 32'd0);
        check("end_i_queue",   32'(exp_i.size()),   32'd0);
        check("end_d_queue",   32'(exp_d.size()),   32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
